// File: rtl/aip_router_pkg.sv
// rtl/aip_router_pkg.sv - shared CSR codes and sizing helpers for the AIP port router
package aip_router_pkg;

    localparam int N_CH_MAX = 16;

    localparam logic [4:0] CFG_SEL_DEF   = 5'h1E;
    localparam logic [4:0] CFG_IRQ_DEF   = 5'h1D;
    localparam logic [4:0] CFG_IEN_DEF   = 5'h1C;
    localparam logic [4:0] CFG_BCAST_DEF = 5'h1B;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aip_irq_latch.sv
// rtl/aip_irq_latch.sv - per-channel interrupt synchroniser, rising-edge detect and pending bit
module aip_irq_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic clr,
    output logic pending
);

    logic sync1;
    logic sync2;
    logic prev;
    logic rise;

    assign rise = sync2 & ~prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
            prev  <= sync2;
            // A new edge beats a simultaneous software clear so no event is lost.
            if (rise)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/aip_port_router.sv
// rtl/aip_port_router.sv - fans one master AIP port out to N_CH slave ports with local CSRs
// and a merged, edge-latched interrupt.
module aip_port_router
    import aip_router_pkg::*;
#(
    parameter int             N_CH      = 4,
    parameter int             DW        = 32,
    parameter int             CW        = 5,
    parameter logic [CW-1:0]  CFG_SEL   = CW'(CFG_SEL_DEF),
    parameter logic [CW-1:0]  CFG_IRQ   = CW'(CFG_IRQ_DEF),
    parameter logic [CW-1:0]  CFG_IEN   = CW'(CFG_IEN_DEF),
    parameter logic [CW-1:0]  CFG_BCAST = CW'(CFG_BCAST_DEF)
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [CW-1:0]      m_aip_config,
    input  logic [DW-1:0]      m_aip_datain,
    input  logic               m_aip_read,
    input  logic               m_aip_write,
    input  logic               m_aip_start,
    input  logic               m_core_int,
    output logic [DW-1:0]      m_aip_dataout,
    output logic               m_aip_rvalid,
    output logic               m_aip_int,
    output logic [N_CH*CW-1:0] s_aip_config,
    output logic [N_CH*DW-1:0] s_aip_datain,
    output logic [N_CH-1:0]    s_aip_read,
    output logic [N_CH-1:0]    s_aip_write,
    output logic [N_CH-1:0]    s_aip_start,
    output logic [N_CH-1:0]    s_core_int,
    input  logic [N_CH*DW-1:0] s_aip_dataout,
    input  logic [N_CH-1:0]    s_aip_int
);

    localparam int SW = clog2_min1(N_CH);

    logic [SW-1:0]   sel;
    logic            sel_oor;
    logic [N_CH-1:0] ien;
    logic [N_CH-1:0] bcast;
    logic [N_CH-1:0] pending;

    logic            is_sel, is_irq, is_ien, is_bcast, csr_hit;
    logic            wr, rd, fwd_wr, fwd_rd;
    logic [N_CH-1:0] sel_oh;
    logic [N_CH-1:0] start_vec;
    logic [N_CH-1:0] irq_clr;
    logic [DW-1:0]   csr_rdata;

    logic            rd_p1;
    logic            rd_csr_p1;
    logic            rd_ok_p1;
    logic [SW-1:0]   rd_sel_p1;
    logic [DW-1:0]   csr_q;
    logic [DW-1:0]   chan_rdata;

    always_comb begin
        is_sel    = (m_aip_config == CFG_SEL);
        is_irq    = (m_aip_config == CFG_IRQ);
        is_ien    = (m_aip_config == CFG_IEN);
        is_bcast  = (m_aip_config == CFG_BCAST);
        csr_hit   = is_sel | is_irq | is_ien | is_bcast;
        wr        = m_aip_write;
        rd        = m_aip_read & ~m_aip_write;
        fwd_wr    = wr & ~csr_hit;
        fwd_rd    = rd & ~csr_hit;
        // An out-of-range select turns every sel-directed action into a no-op.
        sel_oh    = sel_oor ? '0 : (N_CH'(1) << sel);
        start_vec = '0;
        if (m_aip_start)
            start_vec = (bcast != '0) ? bcast : sel_oh;
        irq_clr   = (wr & is_irq) ? m_aip_datain[N_CH-1:0] : '0;
        csr_rdata = '0;
        if (is_sel)
            csr_rdata = DW'(sel);
        else if (is_irq)
            csr_rdata = DW'(pending);
        else if (is_ien)
            csr_rdata = DW'(ien);
        else if (is_bcast)
            csr_rdata = DW'(bcast);
    end

    always_comb begin
        chan_rdata = '0;
        for (int i = 0; i < N_CH; i++)
            if (int'(rd_sel_p1) == i)
                chan_rdata = s_aip_dataout[i*DW +: DW];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sel           <= '0;
            sel_oor       <= 1'b0;
            ien           <= '0;
            bcast         <= '0;
            s_aip_config  <= '0;
            s_aip_datain  <= '0;
            s_aip_read    <= '0;
            s_aip_write   <= '0;
            s_aip_start   <= '0;
            s_core_int    <= '0;
            rd_p1         <= 1'b0;
            rd_csr_p1     <= 1'b0;
            rd_ok_p1      <= 1'b0;
            rd_sel_p1     <= '0;
            csr_q         <= '0;
            m_aip_rvalid  <= 1'b0;
            m_aip_dataout <= '0;
            m_aip_int     <= 1'b0;
        end else begin
            s_aip_read  <= fwd_rd ? sel_oh : '0;
            s_aip_write <= fwd_wr ? sel_oh : '0;
            for (int i = 0; i < N_CH; i++) begin
                if (sel_oh[i] && (fwd_rd || fwd_wr)) begin
                    s_aip_config[i*CW +: CW] <= m_aip_config;
                    s_aip_datain[i*DW +: DW] <= m_aip_datain;
                end
            end
            s_aip_start <= start_vec;
            s_core_int  <= m_core_int ? sel_oh : '0;

            if (wr && is_sel) begin
                sel     <= m_aip_datain[SW-1:0];
                sel_oor <= (m_aip_datain >= DW'(N_CH));
            end
            if (wr && is_ien)
                ien <= m_aip_datain[N_CH-1:0];
            if (wr && is_bcast)
                bcast <= m_aip_datain[N_CH-1:0];

            // Select travels with the read so a later sel write cannot redirect it.
            rd_p1     <= rd;
            rd_csr_p1 <= csr_hit;
            rd_ok_p1  <= ~sel_oor;
            rd_sel_p1 <= sel;
            csr_q     <= csr_rdata;

            m_aip_rvalid <= rd_p1;
            if (rd_p1)
                m_aip_dataout <= rd_csr_p1 ? csr_q : (rd_ok_p1 ? chan_rdata : '0);

            m_aip_int <= |(pending & ien);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_irq
        aip_irq_latch u_irq (
            .clk     (clk_clk),
            .rst_n   (reset_reset_n),
            .irq     (s_aip_int[g]),
            .clr     (irq_clr[g]),
            .pending (pending[g])
        );
    end

endmodule
